// File: rtl/midi_uart_rx_if.sv
// Receive-side byte stream from midi_uart_rx to the MIDI message parser.
// The receiver drives data/valid and the error pulses; the parser drives ready.
interface midi_uart_rx_if;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       frameErr_o;
    logic       overrun_o;

    modport master (output data_o, valid_o, frameErr_o, overrun_o, input ready_i);
    modport slave  (input data_o, valid_o, frameErr_o, overrun_o, output ready_i);
endinterface

// File: rtl/midi_uart_rx.sv
// MIDI 8-N-1 serial receiver with a ready/valid byte stream and error pulses.
// Define MIDI_RX_FIFO_EN for a FIFO_DEPTH-entry buffer; otherwise a single holding register.
module midi_uart_rx #(
    parameter int CLK_FREQ   = 10_000_000,
    parameter int BAUD       = 31250,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk_i,
    input  logic           nrst_i,
    input  logic           rxData_i,
    midi_uart_rx_if.master rx_if
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] HALF_RELOAD = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] BIT_RELOAD  = CW'(DIV - 1);

    if (DIV < 16 || FIFO_DEPTH < 2) begin : g_cfg_chk
        $error("midi_uart_rx: DIV must be >= 16 and FIFO_DEPTH >= 2");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_e;

    logic          sync1_q, rxs_q;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          push, ferr, pop, wr_en, valid;
    logic          ferr_q, ovr_q;
    logic          expire;

    assign expire = (cnt_q == '0);

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            sync1_q <= rxData_i;
            rxs_q   <= sync1_q;
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!rxs_q) state_d = START;
            START:   if (expire) state_d = rxs_q ? IDLE : DATA;
            DATA:    if (expire && idx_q == 3'd7) state_d = STOP;
            STOP:    if (expire) state_d = rxs_q ? IDLE : BRK;
            BRK:     if (rxs_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counter runs freely outside IDLE; only its expiry in START/DATA/STOP matters.
    always_comb begin
        cnt_d   = cnt_q - 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        push    = 1'b0;
        ferr    = 1'b0;
        case (state_q)
            IDLE:  cnt_d = HALF_RELOAD;
            START: if (expire) begin
                cnt_d = BIT_RELOAD;
                idx_d = '0;
            end
            DATA:  if (expire) begin
                cnt_d   = BIT_RELOAD;
                idx_d   = idx_q + 1'b1;
                shift_d = {rxs_q, shift_q[7:1]};
            end
            STOP:  if (expire) begin
                push = rxs_q;
                ferr = !rxs_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            ferr_q  <= ferr;
            ovr_q   <= push && !wr_en;
        end
    end

    assign pop = valid && rx_if.ready_i;

`ifdef MIDI_RX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_q, rd_q;
    logic        full;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign valid = (wr_q != rd_q);
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_q[AW-1:0]] <= shift_q;
                wr_q                <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
        end
    end

    assign rx_if.data_o = mem_q[rd_q[AW-1:0]];
`else
    logic [7:0] hold_q;
    logic       hv_q;

    assign valid = hv_q;
    assign wr_en = push && (!hv_q || pop);

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            hold_q <= '0;
            hv_q   <= 1'b0;
        end else begin
            if (wr_en) hold_q <= shift_q;
            if (wr_en)    hv_q <= 1'b1;
            else if (pop) hv_q <= 1'b0;
        end
    end

    assign rx_if.data_o = hold_q;
`endif

    assign rx_if.valid_o    = valid;
    assign rx_if.frameErr_o = ferr_q;
    assign rx_if.overrun_o  = ovr_q;
endmodule

// File: tb/tb_midi_uart_rx.sv
// Self-checking bench for midi_uart_rx: frame-level byte queue model compared every cycle,
// plus literal latency/count expectations from the directed scenarios.
module tb_midi_uart_rx;
    localparam int DIV = 320;
`ifdef MIDI_RX_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif
    // Push/frame-error edge relative to the driver's falling edge: 2 sync + DIV/2 + 9*DIV + 1.
    localparam int LAT = 2 + DIV / 2 + 9 * DIV + 1;

    typedef struct {
        int         at;
        bit         good;
        logic [7:0] b;
    } ev_t;

    logic clk_i = 1'b0;
    logic nrst_i;
    logic rxData_i;
    midi_uart_rx_if bus();

    midi_uart_rx #(.CLK_FREQ(10_000_000), .BAUD(31250), .FIFO_DEPTH(4)) dut (
        .clk_i   (clk_i),
        .nrst_i  (nrst_i),
        .rxData_i(rxData_i),
        .rx_if   (bus)
    );

    always #50 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int         checks = 0, fails = 0;
    ev_t        evq[$];
    logic [7:0] mq[$];
    logic [7:0] got[$];
    int         rdy_mode = 1;
    int         rise_cyc = -1, hi_cnt = 0, ferr_cnt = 0, ovr_cnt = 0, ovr_first = -1;
    logic       prev_valid = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cyc %0d: got %0h, want %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic line(input logic v, input int n);
        rxData_i = v;
        repeat (n) tick();
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop);
        ev_t e;
        e.at = cyc + LAT;
        e.good = stop;
        e.b = b;
        evq.push_back(e);
        line(1'b0, DIV);
        for (int i = 0; i < 8; i++) line(b[i], DIV);
        line(stop, DIV);
    endtask

    // Consumer: ready held low, held high, or random per cycle.
    initial begin
        bus.ready_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            case (rdy_mode)
                0:       bus.ready_i = 1'b0;
                1:       bus.ready_i = 1'b1;
                default: bus.ready_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Reference model: an ordered byte queue of capacity CAP fed by frame outcomes.
    initial begin
        ev_t        e;
        logic       exp_valid = 1'b0, exp_ferr = 1'b0, exp_ovr = 1'b0;
        logic [7:0] exp_data = 8'h00;
        forever begin
            @(negedge clk_i);
            if (!nrst_i) begin
                mq.delete();
                evq.delete();
                exp_valid = 1'b0;
                exp_data  = 8'h00;
                exp_ferr  = 1'b0;
                exp_ovr   = 1'b0;
            end
            chk("valid", bus.valid_o, exp_valid);
            if (exp_valid) chk("data", bus.data_o, exp_data);
            chk("frameErr", bus.frameErr_o, exp_ferr);
            chk("overrun", bus.overrun_o, exp_ovr);

            if (bus.valid_o && !prev_valid) rise_cyc = cyc;
            prev_valid = bus.valid_o;
            if (bus.valid_o) hi_cnt++;
            if (bus.valid_o && bus.ready_i) got.push_back(bus.data_o);
            if (bus.frameErr_o) ferr_cnt++;
            if (bus.overrun_o) begin
                if (ovr_cnt == 0) ovr_first = cyc;
                ovr_cnt++;
            end

            exp_ferr = 1'b0;
            exp_ovr  = 1'b0;
            if (nrst_i) begin
                if (mq.size() > 0 && bus.ready_i) void'(mq.pop_front());
                while (evq.size() > 0 && evq[0].at <= cyc + 1) begin
                    e = evq.pop_front();
                    if (!e.good)             exp_ferr = 1'b1;
                    else if (mq.size() < CAP) mq.push_back(e.b);
                    else                     exp_ovr = 1'b1;
                end
            end
            exp_valid = (mq.size() > 0);
            exp_data  = exp_valid ? mq[0] : 8'h00;
        end
    end

    initial begin
        int         n;
        int         nb[6];
        logic [7:0] rb;
        bit         good;
        nrst_i   = 1'b0;
        rxData_i = 1'b1;
        repeat (5) tick();
        chk("rst_data", bus.data_o, 8'h00);
        chk("rst_valid", bus.valid_o, 1'b0);
        chk("rst_ferr", bus.frameErr_o, 1'b0);
        chk("rst_ovr", bus.overrun_o, 1'b0);
        nrst_i = 1'b1;
        line(1'b1, 20);

        // Single byte, zero-wait consumer
        got.delete(); hi_cnt = 0; ferr_cnt = 0;
        n = cyc;
        send_frame(8'h90, 1'b1);
        line(1'b1, 20);
        chk("lat_0x90", rise_cyc - n, 3043);
        chk("hi_cycles", hi_cnt, 1);
        chk("ferr_none", ferr_cnt, 0);
        chk("got1_n", got.size(), 1);
        chk("got1_0", got[0], 8'h90);

        // Back-to-back frames
        got.delete();
        send_frame(8'h90, 1'b1);
        send_frame(8'h3C, 1'b1);
        send_frame(8'h7F, 1'b1);
        line(1'b1, 20);
        chk("b2b_n", got.size(), 3);
        chk("b2b_0", got[0], 8'h90);
        chk("b2b_1", got[1], 8'h3C);
        chk("b2b_2", got[2], 8'h7F);
        chk("b2b_ferr", ferr_cnt, 0);

        // Short low glitch
        got.delete();
        line(1'b0, 40);
        line(1'b1, 400);
        chk("glitch_n", got.size(), 0);
        chk("glitch_ferr", ferr_cnt, 0);

        // Framing error followed by held-low break
        send_frame(8'h55, 1'b0);
        line(1'b0, 2000);
        line(1'b1, 100);
        chk("brk_ferr", ferr_cnt, 1);
        chk("brk_n", got.size(), 0);
        send_frame(8'h12, 1'b1);
        line(1'b1, 20);
        chk("after_brk_n", got.size(), 1);
        chk("after_brk_0", got[0], 8'h12);

        // Overrun with stalled consumer
        rdy_mode = 0; got.delete(); ovr_cnt = 0; ovr_first = -1;
        for (int b = 1; b <= 5; b++) begin
            nb[b] = cyc;
            send_frame(8'(b), 1'b1);
        end
        line(1'b1, 20);
        chk("ovr_cnt", ovr_cnt, 5 - CAP);
        chk("ovr_at", ovr_first - nb[CAP + 1], 3043);
        chk("ovr_head", bus.data_o, 8'h01);
        rdy_mode = 1;
        line(1'b1, 20);
        chk("drain_n", got.size(), CAP);
        for (int i = 0; i < CAP; i++) chk("drain_data", got[i], 32'(i + 1));

        // Reset mid-byte with one byte buffered
        rdy_mode = 0;
        send_frame(8'h11, 1'b1);
        line(1'b1, 20);
        chk("pre_rst_valid", bus.valid_o, 1'b1);
        rb = 8'hAA;
        line(1'b0, DIV);
        for (int i = 0; i < 4; i++) line(rb[i], DIV);
        line(rb[4], DIV / 2);
        nrst_i = 1'b0;
        #1;
        chk("mid_rst_valid", bus.valid_o, 1'b0);
        chk("mid_rst_data", bus.data_o, 8'h00);
        tick();
        line(1'b1, 3);
        nrst_i = 1'b1;
        rdy_mode = 1;
        line(1'b1, 50);
        got.delete();
        send_frame(8'h3C, 1'b1);
        line(1'b1, 20);
        chk("post_rst_n", got.size(), 1);
        chk("post_rst_0", got[0], 8'h3C);

        // Randomized frames, gaps and consumer stalls
        rdy_mode = 2;
        for (int k = 0; k < 4; k++) begin
            rb   = 8'($urandom);
            good = ($urandom_range(0, 3) != 0);
            send_frame(rb, good);
            line(1'b1, good ? $urandom_range(0, 150) : $urandom_range(20, 150));
        end
        rdy_mode = 1;
        line(1'b1, 50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
